// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the multicycle CPU: one request at a time, fixed wait
// states, word read/write on an internal register array, one-cycle ready pulse.
module cpu_mem_responder #(
  parameter int ADDR_W   = 6,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_next;
  logic                r_we;
  logic [ADDR_W+1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic [31:0]         r_mem [DEPTH];

  logic                w_acc_we;
  logic [ADDR_W+1:0]   w_acc_addr;
  logic [31:0]         w_acc_wdata;
  logic [ADDR_W-1:0]   w_idx;
  logic                w_misaligned;
  logic                w_enter_resp;
  logic                w_unused;

  // Addresses alias modulo the memory size, so the upper byte-address bits are dropped.
  assign w_unused = ^addr[31:ADDR_W+2];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_CYC == 0) begin
            w_next = ST_RESP;
          end else begin
            w_next     = ST_WAIT;
            w_cnt_next = 4'(WAIT_CYC - 1);
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) w_next = ST_RESP;
        else               w_cnt_next = r_cnt - 4'd1;
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // With zero wait states the access happens on the accepting edge, before the latch holds it.
  assign w_acc_we     = (r_state == ST_IDLE) ? we              : r_we;
  assign w_acc_addr   = (r_state == ST_IDLE) ? addr[ADDR_W+1:0] : r_addr;
  assign w_acc_wdata  = (r_state == ST_IDLE) ? wdata           : r_wdata;
  assign w_idx        = w_acc_addr[ADDR_W+1:2];
  assign w_misaligned = |w_acc_addr[1:0];
  assign w_enter_resp = (w_next == ST_RESP) && (r_state != ST_RESP);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (r_state == ST_IDLE && req) begin
        r_we    <= we;
        r_addr  <= addr[ADDR_W+1:0];
        r_wdata <= wdata;
      end
      if (w_enter_resp) begin
        r_err <= w_misaligned;
        if (w_misaligned)   r_rdata <= 32'd0;
        else if (!w_acc_we) r_rdata <= r_mem[w_idx];
      end
    end
  end

  // NOTE: the storage array has no reset; its contents are undefined until written.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_acc_we && !w_misaligned) r_mem[w_idx] <= w_acc_wdata;
  end

  assign rdata = r_rdata;
  assign err   = r_err;
  assign ready = (r_state == ST_RESP);

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: a driver queues expected responses from a
// word-array model, a negedge monitor checks each ready pulse; a second instance covers zero wait states.
module tb_cpu_mem_responder;

  localparam int ADDR_W   = 6;
  localparam int WAIT_CYC = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  logic        req0   = 1'b0;
  logic        we0    = 1'b0;
  logic [31:0] addr0  = 32'd0;
  logic [31:0] wdata0 = 32'd0;
  logic [31:0] rdata0;
  logic        ready0;
  logic        err0;

  always #5 clk = ~clk;

  cpu_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err)
  );

  cpu_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .err(err0)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          chk_rdata;
    int          cycle;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem[int];
  logic [31:0] model_rdata = 32'd0;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          scramble = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a % (32'd1 << (ADDR_W + 2))) / 32'd4);
  endfunction

  // Present one request at posedge+1 and hold it until ready; returns at posedge+1 with req still high.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit   got;
    int   idx;
    idx         = word_of(a);
    req         = 1'b1;
    we          = w;
    addr        = a;
    wdata       = d;
    e.cycle     = cyc + WAIT_CYC + 1;
    e.err       = (a % 4) != 0;
    e.chk_rdata = 1'b1;
    if (e.err) begin
      e.rdata     = 32'd0;
      model_rdata = 32'd0;
    end else if (w) begin
      model_mem[idx] = d;
      e.rdata        = model_rdata;
    end else if (model_mem.exists(idx)) begin
      e.rdata     = model_mem[idx];
      model_rdata = e.rdata;
    end else begin
      e.rdata     = 32'd0;
      e.chk_rdata = 1'b0;
    end
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ready) got = 1'b1;
      else if (scramble && i > 0) begin
        addr  = $urandom;
        wdata = $urandom;
        we    = 1'($urandom);
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got no ready expected ready by cycle %0d", e.cycle);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run0(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    int c0;
    c0     = cyc;
    rd     = 32'd0;
    er     = 1'b0;
    lat    = -1;
    req0   = 1'b1;
    we0    = w;
    addr0  = a;
    wdata0 = d;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready0) begin
        lat = cyc - c0;
        rd  = rdata0;
        er  = err0;
        break;
      end
    end
    @(posedge clk);
    #1;
    req0 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ready pulse must match the oldest queued expectation.
  logic prev_ready = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && ready) begin
      check("ready_width", 32'(prev_ready), 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: got ready expected none (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("latency", 32'(cyc), 32'(mon_e.cycle));
        check("err", 32'(err), 32'(mon_e.err));
        if (mon_e.chk_rdata) check("rdata", rdata, mon_e.rdata);
      end
    end
    prev_ready = ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd0;
    logic        er0;
    int          lat0;
    logic [31:0] a;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ready0", 32'(ready0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill every word back-to-back so later reads have defined expectations.
    for (int i = 0; i < (1 << ADDR_W); i++) issue(1'b1, 32'(i * 4), $urandom);
    idle(1);

    issue(1'b1, 32'h08, 32'hDEADBEEF);  idle(1);
    issue(1'b0, 32'h08, 32'h0);         idle(2);
    issue(1'b1, 32'h0A, 32'h12345678);  idle(1);
    issue(1'b0, 32'h08, 32'h0);         idle(1);
    issue(1'b1, 32'h104, 32'h5A5A5A5A); idle(1);
    issue(1'b0, 32'h004, 32'h0);        idle(1);

    for (int i = 0; i < 8; i++) issue(1'b0, (i % 2 == 0) ? 32'h00 : 32'h04, 32'h0);
    idle(1);

    // Reset during WAIT of a write must abort it: no write and no ready.
    issue(1'b1, 32'h10, 32'h1); idle(1);
    issue(1'b0, 32'h10, 32'h0); idle(1);
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'h10;
    wdata = 32'hCAFEF00D;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_ready", 32'(ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    model_rdata = 32'd0;
    idle(6);
    issue(1'b0, 32'h10, 32'h0); idle(1);

    // Randomized traffic with aliased high bits, occasional misalignment, and random gaps.
    for (int i = 0; i < 60; i++) begin
      a = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, (1 << ADDR_W) - 1) * 4);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      issue(1'($urandom), a, $urandom);
      idle($urandom_range(0, 2));
    end
    idle(4);

    // Zero wait states: ready in the cycle right after the request is taken.
    run0(1'b1, 32'h20, 32'hA5A5_0F0F, rd0, er0, lat0);
    check("w0_wr_lat", 32'(lat0), 32'd1);
    check("w0_wr_err", 32'(er0), 32'd0);
    run0(1'b0, 32'h20, 32'h0, rd0, er0, lat0);
    check("w0_rd_lat", 32'(lat0), 32'd1);
    check("w0_rd_data", rd0, 32'hA5A5_0F0F);
    check("w0_rd_err", 32'(er0), 32'd0);
    run0(1'b0, 32'h23, 32'h0, rd0, er0, lat0);
    check("w0_mis_lat", 32'(lat0), 32'd1);
    check("w0_mis_err", 32'(er0), 32'd1);
    check("w0_mis_data", rd0, 32'd0);
    run0(1'b0, 32'h820, 32'h0, rd0, er0, lat0);
    check("w0_alias_data", rd0, 32'hA5A5_0F0F);

    repeat (5) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
